// File: rtl/sorted_table_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : sorted_table_engine_if
// Description : Command/result bundle between the operator controls and the
//               sorted_table_engine operation core.
//               master : drives OpRegIn/LoadOpReg/OpCodeIn/Execute,
//                        observes OpReg/ShowOpReg/OpCode/ShowOpCode/
//                        OpResult/Busy.
//               slave  : the engine side (directions reversed).
// Revision    : 1.0 - initial release
// ============================================================================
interface sorted_table_engine_if;
   logic [7:0]  OpRegIn;     // operand from switches
   logic        LoadOpReg;   // one-cycle pulse: latch OpRegIn
   logic [2:0]  OpCodeIn;    // command select
   logic        Execute;     // one-cycle pulse: latch OpCodeIn and run it
   logic [7:0]  OpReg;       // latched operand
   logic        ShowOpReg;   // pulse the cycle after an accepted load
   logic [2:0]  OpCode;      // latched command
   logic        ShowOpCode;  // pulse the cycle after an accepted execute
   logic [23:0] OpResult;    // {status, 4'h0, index, value}
   logic        Busy;        // command in progress

   modport master (
      output OpRegIn, LoadOpReg, OpCodeIn, Execute,
      input  OpReg, ShowOpReg, OpCode, ShowOpCode, OpResult, Busy
   );

   modport slave (
      input  OpRegIn, LoadOpReg, OpCodeIn, Execute,
      output OpReg, ShowOpReg, OpCode, ShowOpCode, OpResult, Busy
   );
endinterface
`default_nettype wire

// File: rtl/sorted_table_engine.sv
`default_nettype none
// ============================================================================
// Module      : sorted_table_engine
// Description : Holds a sorted, duplicate-free table of 8-bit keys and runs
//               clear/insert/delete/search/read/count/min/max commands on the
//               latched operand. Key lookups use a one-probe-per-cycle binary
//               search; insert/delete move one entry per cycle.
// Ports       : clk  - system clock
//               rst  - asynchronous active-high reset
//               bus  - sorted_table_engine_if.slave (operand/command inputs,
//                      display outputs, result word and Busy)
// Revision    : 1.0 - initial release
// ============================================================================
module sorted_table_engine #(
   parameter int DEPTH = 16
) (
   input  wire logic             clk,
   input  wire logic             rst,
   sorted_table_engine_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] c_S_IDLE   = 2'd0;
   localparam logic [1:0] c_S_SEARCH = 2'd1;
   localparam logic [1:0] c_S_SHIFT  = 2'd2;
   localparam logic [1:0] c_S_DONE   = 2'd3;

   localparam logic [2:0] c_CMD_CLEAR  = 3'd0;
   localparam logic [2:0] c_CMD_INSERT = 3'd1;
   localparam logic [2:0] c_CMD_DELETE = 3'd2;
   localparam logic [2:0] c_CMD_SEARCH = 3'd3;
   localparam logic [2:0] c_CMD_READ   = 3'd4;
   localparam logic [2:0] c_CMD_COUNT  = 3'd5;
   localparam logic [2:0] c_CMD_MIN    = 3'd6;
   localparam logic [2:0] c_CMD_MAX    = 3'd7;

   localparam logic [3:0] c_STAT_NOTFOUND = 4'hF;
   localparam logic [3:0] c_STAT_FULL     = 4'hE;
   localparam logic [3:0] c_STAT_DUP      = 4'hD;
   localparam logic [3:0] c_STAT_BADIDX   = 4'hC;
   localparam logic [3:0] c_STAT_EMPTY    = 4'hB;

   localparam logic [AW:0] c_ONE  = (AW+1)'(1);
   localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [1:0]  r_state;
   logic [7:0]  r_op_reg;
   logic [2:0]  r_op_code;
   logic        r_show_op_reg;
   logic        r_show_op_code;
   logic        r_busy;
   logic [23:0] r_result;
   logic [23:0] r_pend;          // result staged until the DONE edge
   logic [7:0]  r_tbl [DEPTH];
   logic [AW:0] r_count;
   logic [AW:0] r_lo;
   logic [AW:0] r_hi;
   logic [AW:0] r_pos;           // insert position
   logic [AW:0] r_ptr;           // shift cursor

   // Zero-extend an index/count to the 8-bit index field.
   function automatic logic [7:0] ext8(input logic [AW:0] v);
      logic [7:0] r;
      r       = '0;
      r[AW:0] = v;
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic [7:0]  w_key;           // operand as seen by a command issued now
   logic [7:0]  w_count8;
   logic [AW:0] w_last;
   logic [AW:0] w_mid;
   logic [7:0]  w_probe;
   logic        w_lt;
   logic        w_eq;
   logic [AW:0] w_nlo;
   logic [AW:0] w_nhi;
   logic        w_exit;
   logic        w_found;
   logic [AW:0] w_pos;
   logic [AW:0] w_ptr_dn;
   logic [AW:0] w_ptr_up;
   logic [23:0] w_quick;         // result of commands needing no search
   logic        w_is_lookup;

   // A load in the same cycle as an execute lands first.
   assign w_key    = bus.LoadOpReg ? bus.OpRegIn : r_op_reg;
   assign w_count8 = ext8(r_count);
   assign w_last   = r_count - c_ONE;
   assign w_ptr_dn = r_ptr - c_ONE;
   assign w_ptr_up = r_ptr + c_ONE;

   assign w_is_lookup = (bus.OpCodeIn == c_CMD_INSERT) ||
                        (bus.OpCodeIn == c_CMD_DELETE) ||
                        (bus.OpCodeIn == c_CMD_SEARCH);

   // Binary-search probe. Written as lo + (hi-lo)/2 so the sum never needs
   // an extra carry bit; the value equals (lo+hi)>>1.
   always_comb begin
      w_mid   = r_lo + ((r_hi - r_lo) >> 1);
      w_probe = r_tbl[w_mid[AW-1:0]];
      w_lt    = (w_probe < r_op_reg);
      w_eq    = (w_probe == r_op_reg);
      w_nlo   = w_lt ? (w_mid + c_ONE) : r_lo;
      w_nhi   = w_lt ? r_hi : w_mid;
      // lo==hi on entry only happens for an empty table: exit without probing.
      // Otherwise exit on a hit or when the updated window collapses, so the
      // last probe and the exit share one cycle.
      w_exit  = (r_lo == r_hi) || w_eq || (w_nlo == w_nhi);
      w_found = (r_lo != r_hi) && w_eq;
      if (r_lo == r_hi) begin
         w_pos = r_lo;
      end else if (w_eq) begin
         w_pos = w_mid;
      end else begin
         w_pos = w_nlo;
      end
   end

   always_comb begin
      w_quick = '0;
      case (bus.OpCodeIn)
         c_CMD_READ: begin
            if (w_key >= w_count8) begin
               w_quick = {c_STAT_BADIDX, 20'h0};
            end else begin
               w_quick = {8'h00, ext8({1'b0, w_key[AW-1:0]}), r_tbl[w_key[AW-1:0]]};
            end
         end
         c_CMD_COUNT: w_quick = {8'h00, w_count8, 8'h00};
         c_CMD_MIN: begin
            if (r_count == '0) begin
               w_quick = {c_STAT_EMPTY, 20'h0};
            end else begin
               w_quick = {8'h00, 8'h00, r_tbl[0]};
            end
         end
         c_CMD_MAX: begin
            if (r_count == '0) begin
               w_quick = {c_STAT_EMPTY, 20'h0};
            end else begin
               w_quick = {8'h00, ext8(w_last), r_tbl[w_last[AW-1:0]]};
            end
         end
         default: w_quick = '0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= c_S_IDLE;
         r_op_reg       <= '0;
         r_op_code      <= '0;
         r_show_op_reg  <= 1'b0;
         r_show_op_code <= 1'b0;
         r_busy         <= 1'b0;
         r_result       <= '0;
         r_pend         <= '0;
         r_count        <= '0;
         r_lo           <= '0;
         r_hi           <= '0;
         r_pos          <= '0;
         r_ptr          <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_tbl[i] <= '0;
         end
      end else begin
         r_show_op_reg  <= 1'b0;
         r_show_op_code <= 1'b0;
         case (r_state)
            c_S_IDLE: begin
               if (bus.LoadOpReg) begin
                  r_op_reg      <= bus.OpRegIn;
                  r_show_op_reg <= 1'b1;
               end
               if (bus.Execute) begin
                  r_op_code      <= bus.OpCodeIn;
                  r_show_op_code <= 1'b1;
                  r_busy         <= 1'b1;
                  r_pend         <= w_quick;
                  if (w_is_lookup) begin
                     r_lo    <= '0;
                     r_hi    <= r_count;
                     r_state <= c_S_SEARCH;
                  end else begin
                     if (bus.OpCodeIn == c_CMD_CLEAR) begin
                        r_count <= '0;
                     end
                     r_state <= c_S_DONE;
                  end
               end
            end

            c_S_SEARCH: begin
               if (w_exit) begin
                  case (r_op_code)
                     c_CMD_INSERT: begin
                        // Duplicate check precedes the full check.
                        if (w_found) begin
                           r_pend  <= {c_STAT_DUP, 4'h0, ext8(w_pos), r_op_reg};
                           r_state <= c_S_DONE;
                        end else if (r_count == c_FULL) begin
                           r_pend  <= {c_STAT_FULL, 20'h0};
                           r_state <= c_S_DONE;
                        end else begin
                           r_pend  <= {8'h00, ext8(w_pos), r_op_reg};
                           r_pos   <= w_pos;
                           r_ptr   <= r_count;
                           r_state <= c_S_SHIFT;
                        end
                     end
                     c_CMD_DELETE: begin
                        if (w_found) begin
                           r_pend  <= {8'h00, ext8(w_pos), r_op_reg};
                           r_ptr   <= w_pos;
                           r_state <= c_S_SHIFT;
                        end else begin
                           r_pend  <= (r_count == '0) ? {c_STAT_EMPTY, 20'h0}
                                                      : {c_STAT_NOTFOUND, 20'h0};
                           r_state <= c_S_DONE;
                        end
                     end
                     default: begin
                        if (w_found) begin
                           r_pend <= {8'h00, ext8(w_pos), r_op_reg};
                        end else if (r_count == '0) begin
                           r_pend <= {c_STAT_EMPTY, 20'h0};
                        end else begin
                           // A failed search still reports where the key would go.
                           r_pend <= {c_STAT_NOTFOUND, 4'h0, ext8(w_pos), 8'h00};
                        end
                        r_state <= c_S_DONE;
                     end
                  endcase
               end else begin
                  r_lo <= w_nlo;
                  r_hi <= w_nhi;
               end
            end

            c_S_SHIFT: begin
               if (r_op_code == c_CMD_INSERT) begin
                  // Open a hole at r_pos by walking down from the top.
                  if (r_ptr == r_pos) begin
                     r_tbl[r_pos[AW-1:0]] <= r_op_reg;
                     r_count              <= r_count + c_ONE;
                     r_state              <= c_S_DONE;
                  end else begin
                     r_tbl[r_ptr[AW-1:0]] <= r_tbl[w_ptr_dn[AW-1:0]];
                     r_ptr                <= w_ptr_dn;
                  end
               end else begin
                  // Close the hole at the deleted slot by walking upward.
                  if (w_ptr_up < r_count) begin
                     r_tbl[r_ptr[AW-1:0]] <= r_tbl[w_ptr_up[AW-1:0]];
                     r_ptr                <= w_ptr_up;
                  end else begin
                     r_count <= r_count - c_ONE;
                     r_state <= c_S_DONE;
                  end
               end
            end

            c_S_DONE: begin
               r_result <= r_pend;
               r_busy   <= 1'b0;
               r_state  <= c_S_IDLE;
            end

            default: r_state <= c_S_IDLE;
         endcase
      end
   end

   assign bus.OpReg      = r_op_reg;
   assign bus.ShowOpReg  = r_show_op_reg;
   assign bus.OpCode     = r_op_code;
   assign bus.ShowOpCode = r_show_op_code;
   assign bus.OpResult   = r_result;
   assign bus.Busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sorted_table_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_sorted_table_engine
// Description : Self-checking bench for sorted_table_engine. Command vectors
//               with expected results are applied from a table; expected
//               results go to a scoreboard queue when a command is issued and
//               are compared when Busy falls. Hand-written sequences cover
//               same-cycle load/execute, inputs while busy and reset during
//               a shift.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sorted_table_engine;

   typedef struct packed {
      logic [2:0]  op;
      logic [7:0]  key;
      logic [23:0] exp;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic prev_busy;

   vec_t        vecs[$];
   logic [23:0] sb_q[$];

   sorted_table_engine_if bus();

   sorted_table_engine #(.DEPTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic void add(input logic [2:0] op, input logic [7:0] key, input logic [23:0] exp);
      vec_t v;
      v.op  = op;
      v.key = key;
      v.exp = exp;
      vecs.push_back(v);
   endfunction

   // Scoreboard consumer: a falling Busy edge delivers one result.
   always @(negedge clk) begin
      logic [23:0] e;
      if (rst) begin
         prev_busy = 1'b0;
      end else begin
         if (prev_busy && !bus.Busy) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result actual=%h required=none", bus.OpResult);
            end else begin
               e = sb_q.pop_front();
               check("result", {8'h0, bus.OpResult}, {8'h0, e});
            end
         end
         prev_busy = bus.Busy;
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.Busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bus.Busy) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout actual=1 required=0");
      end
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [7:0] key, input logic [23:0] exp);
      @(negedge clk);
      bus.OpRegIn   = key;
      bus.LoadOpReg = 1'b1;
      @(negedge clk);
      bus.LoadOpReg = 1'b0;
      bus.OpCodeIn  = op;
      bus.Execute   = 1'b1;
      sb_q.push_back(exp);
      @(negedge clk);
      bus.Execute = 1'b0;
      wait_idle();
   endtask

   task automatic run_range(input int first, input int last);
      for (int i = first; i < last; i++) begin
         run_cmd(vecs[i].op, vecs[i].key, vecs[i].exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int na;
      int nb;
      checks        = 0;
      errors        = 0;
      prev_busy     = 1'b0;
      rst           = 1'b1;
      bus.OpRegIn   = '0;
      bus.LoadOpReg = 1'b0;
      bus.OpCodeIn  = '0;
      bus.Execute   = 1'b0;

      // ---- vector table ----------------------------------------------------
      // Phase A: basic insert/read/search/delete
      add(3'd1, 8'h50, 24'h000050);
      add(3'd1, 8'h10, 24'h000010);
      add(3'd1, 8'h30, 24'h000130);
      add(3'd5, 8'h00, 24'h000300);
      add(3'd4, 8'h00, 24'h000010);
      add(3'd4, 8'h01, 24'h000130);
      add(3'd4, 8'h02, 24'h000250);
      add(3'd3, 8'h20, 24'hF00100);
      add(3'd3, 8'h50, 24'h000250);
      add(3'd2, 8'h10, 24'h000010);
      add(3'd6, 8'h00, 24'h000030);
      add(3'd7, 8'h00, 24'h000150);
      add(3'd2, 8'h99, 24'hF00000);
      add(3'd4, 8'h05, 24'hC00000);
      na = vecs.size();
      // Phase B: fill to capacity in descending order, boundaries
      add(3'd0, 8'h00, 24'h000000);
      for (int k = 15; k >= 0; k--) add(3'd1, 8'(k), {16'h0000, 8'(k)});
      for (int k = 0; k < 16; k++)  add(3'd4, 8'(k), {8'h00, 8'(k), 8'(k)});
      add(3'd1, 8'h80, 24'hE00000);
      add(3'd1, 8'h05, 24'hD00505);
      add(3'd5, 8'h00, 24'h001000);
      add(3'd7, 8'h00, 24'h000F0F);
      add(3'd3, 8'h0F, 24'h000F0F);
      add(3'd3, 8'h00, 24'h000000);
      add(3'd2, 8'h0F, 24'h000F0F);
      add(3'd5, 8'h00, 24'h000F00);
      add(3'd2, 8'h00, 24'h000000);
      add(3'd6, 8'h00, 24'h000001);
      add(3'd1, 8'h80, 24'h000E80);
      nb = vecs.size();
      // Phase C: after reset, empty-table behaviour
      add(3'd5, 8'h00, 24'h000000);
      add(3'd0, 8'h00, 24'h000000);
      add(3'd6, 8'h00, 24'hB00000);
      add(3'd7, 8'h00, 24'hB00000);
      add(3'd3, 8'h20, 24'hB00000);
      add(3'd2, 8'h20, 24'hB00000);
      add(3'd4, 8'h00, 24'hC00000);
      add(3'd1, 8'hFF, 24'h0000FF);
      add(3'd4, 8'h00, 24'h0000FF);
      add(3'd4, 8'h01, 24'hC00000);
      add(3'd1, 8'hFF, 24'hD000FF);

      // ---- reset state -----------------------------------------------------
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_opreg",      {24'h0, bus.OpReg},      32'h0);
      check("rst_opcode",     {29'h0, bus.OpCode},     32'h0);
      check("rst_result",     {8'h0, bus.OpResult},    32'h0);
      check("rst_busy",       {31'h0, bus.Busy},       32'h0);
      check("rst_showopreg",  {31'h0, bus.ShowOpReg},  32'h0);
      check("rst_showopcode", {31'h0, bus.ShowOpCode}, 32'h0);

      run_range(0, na);

      // ---- same-cycle load+execute, then inputs while busy -----------------
      @(negedge clk);
      bus.OpRegIn   = 8'h30;
      bus.LoadOpReg = 1'b1;
      bus.OpCodeIn  = 3'd3;
      bus.Execute   = 1'b1;
      sb_q.push_back(24'h000030);
      @(negedge clk);
      check("same_showopreg",  {31'h0, bus.ShowOpReg},  32'h1);
      check("same_showopcode", {31'h0, bus.ShowOpCode}, 32'h1);
      check("same_opreg",      {24'h0, bus.OpReg},      32'h30);
      check("same_busy",       {31'h0, bus.Busy},       32'h1);
      bus.OpRegIn   = 8'hAA;
      bus.OpCodeIn  = 3'd5;
      @(negedge clk);
      check("ign_showopreg",  {31'h0, bus.ShowOpReg},  32'h0);
      check("ign_showopcode", {31'h0, bus.ShowOpCode}, 32'h0);
      check("ign_opreg",      {24'h0, bus.OpReg},      32'h30);
      check("ign_opcode",     {29'h0, bus.OpCode},     32'h3);
      bus.LoadOpReg = 1'b0;
      bus.Execute   = 1'b0;
      wait_idle();
      @(negedge clk);
      check("ign_opreg_after", {24'h0, bus.OpReg}, 32'h30);

      run_range(na, nb);

      // ---- reset during the shift phase of an insert -----------------------
      @(negedge clk);
      bus.OpRegIn   = 8'h00;
      bus.LoadOpReg = 1'b1;
      @(negedge clk);
      bus.LoadOpReg = 1'b0;
      bus.OpCodeIn  = 3'd1;
      bus.Execute   = 1'b1;
      @(negedge clk);
      bus.Execute = 1'b0;
      repeat (8) @(negedge clk);
      check("mid_busy_before", {31'h0, bus.Busy}, 32'h1);
      rst = 1'b1;
      #1;
      check("mid_busy",   {31'h0, bus.Busy},    32'h0);
      check("mid_result", {8'h0, bus.OpResult}, 32'h0);
      check("mid_opreg",  {24'h0, bus.OpReg},   32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_range(nb, vecs.size());

      @(negedge clk);
      check("scoreboard_empty", sb_q.size(), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
